// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ID/EX ALU-control slice: ALUOp classes, op codes, FSM states.
package alu_ctrl_pkg;

   typedef enum logic [1:0] {
      ALUOP_MEM = 2'b00,
      ALUOP_BR  = 2'b01,
      ALUOP_RI  = 2'b10,
      ALUOP_JL  = 2'b11
   } aluop_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MEXT = 7'b0000001;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_LUI = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLL = 4'b0111;
   localparam logic [3:0] OP_BEQ = 4'b1000;
   localparam logic [3:0] OP_BNE = 4'b1001;
   localparam logic [3:0] OP_BGE = 4'b1010;
   localparam logic [3:0] OP_BLT = 4'b1011;
   localparam logic [3:0] OP_SLT = 4'b1100;
   localparam logic [3:0] OP_SRA = 4'b1110;
   localparam logic [3:0] OP_SRL = 4'b1111;

   localparam logic [1:0] MOP_PFX = 2'b10;

   // MUL=10000 .. REMU=10111
   function automatic logic [4:0] mop_code(input logic [2:0] f3);
      return {MOP_PFX, f3};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/Funct7/Funct3 decode into {is_mop, illegal, op}.
// Latency: none (pure logic); backpressure: none, the caller qualifies inputs.
module alu_op_decode
   import alu_ctrl_pkg::*;
#(
   parameter int OP_W    = 5,
   parameter bit EN_MEXT = 1'b1
) (
   input  logic [1:0]      aluop,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   output logic            is_mop,
   output logic            illegal,
   output logic [OP_W-1:0] op
);

   logic [3:0] base;

   always_comb begin
      is_mop  = 1'b0;
      illegal = 1'b0;
      base    = OP_AND;
      case (aluop)
         ALUOP_MEM: base = OP_ADD;
         ALUOP_BR: begin
            case (funct3)
               3'b000:  base = OP_BEQ;
               3'b001:  base = OP_BNE;
               3'b101:  base = OP_BGE;
               3'b100:  base = OP_BLT;
               default: illegal = 1'b1;
            endcase
         end
         ALUOP_RI: begin
            if (funct7 == F7_MEXT) begin
               if (EN_MEXT) is_mop = 1'b1;
               else         illegal = 1'b1;
            end else begin
               case (funct3)
                  3'b000: base = (funct7 == F7_ALT) ? OP_SUB : OP_ADD;
                  3'b001: begin
                     if (funct7 == F7_BASE) base = OP_SLL;
                     else                   illegal = 1'b1;
                  end
                  3'b010: base = OP_SLT;
                  3'b100: base = OP_XOR;
                  3'b101: begin
                     if (funct7 == F7_BASE)     base = OP_SRL;
                     else if (funct7 == F7_ALT) base = OP_SRA;
                     else                       illegal = 1'b1;
                  end
                  3'b110:  base = OP_OR;
                  3'b111:  base = OP_AND;
                  default: illegal = 1'b1;
               endcase
            end
         end
         ALUOP_JL: begin
            case (funct3)
               3'b000:  base = OP_BLT;
               3'b001:  base = OP_LUI;
               default: illegal = 1'b1;
            endcase
         end
      endcase
   end

   assign op = illegal ? '0 :
               is_mop  ? OP_W'(mop_code(funct3)) : OP_W'(base);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control with a start/done sequencer for an external mul/div unit.
// Latency: base ops 1 cycle; M-ops issue+wait until done or timeout; stalls upstream while busy.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter  int OP_W       = 5,
   parameter  bit EN_MEXT    = 1'b1,
   parameter  int MD_TIMEOUT = 64,
   localparam int CNT_W      = $clog2(MD_TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            valid_i,
   input  logic [1:0]      ALUOp,
   input  logic [6:0]      Funct7,
   input  logic [2:0]      Funct3,
   output logic            ready_o,
   output logic            stall_o,
   output logic [OP_W-1:0] Operation,
   output logic            op_valid_o,
   output logic            illegal_o,
   output logic            md_start_o,
   output logic [2:0]      md_op_o,
   input  logic            md_done_i,
   output logic            md_kill_o,
   output logic            md_err_o
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        md_op_d;
   logic [OP_W-1:0]   op_d;
   logic              opv_d, ill_d, kill_d, err_d;
   logic              dec_is_mop, dec_illegal;
   logic [OP_W-1:0]   dec_op;

   alu_op_decode #(.OP_W(OP_W), .EN_MEXT(EN_MEXT)) u_dec (
      .aluop   (ALUOp),
      .funct7  (Funct7),
      .funct3  (Funct3),
      .is_mop  (dec_is_mop),
      .illegal (dec_illegal),
      .op      (dec_op)
   );

   assign stall_o    = (state_q != IDLE);
   assign ready_o    = ~stall_o;
   assign md_start_o = (state_q == ISSUE);

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      md_op_d = md_op_o;
      op_d    = Operation;
      ill_d   = illegal_o;
      opv_d   = 1'b0;
      kill_d  = 1'b0;
      err_d   = md_err_o;
      if (flush_i) begin
         // Drop any accepted instruction; tell the mul/div unit only if it was engaged.
         state_d = IDLE;
         kill_d  = (state_q != IDLE);
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_i) begin
                  if (dec_is_mop) begin
                     md_op_d = Funct3;
                     state_d = ISSUE;
                  end else begin
                     opv_d = 1'b1;
                     op_d  = dec_op;
                     ill_d = dec_illegal;
                  end
               end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
               // done takes priority over a timeout landing on the same cycle
               if (md_done_i) begin
                  opv_d   = 1'b1;
                  op_d    = OP_W'(mop_code(md_op_o));
                  ill_d   = 1'b0;
                  state_d = IDLE;
               end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
                  opv_d   = 1'b1;
                  op_d    = '0;
                  ill_d   = 1'b1;
                  kill_d  = 1'b1;
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         md_op_o    <= '0;
         Operation  <= '0;
         illegal_o  <= 1'b0;
         op_valid_o <= 1'b0;
         md_kill_o  <= 1'b0;
         md_err_o   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         md_op_o    <= md_op_d;
         Operation  <= op_d;
         illegal_o  <= ill_d;
         op_valid_o <= opv_d;
         md_kill_o  <= kill_d;
         md_err_o   <= err_d;
      end
   end

endmodule
